// File: rtl/lzd_share_arbiter.sv
// Round-robin shared 48-bit leading-zero-detect/normalize unit.
// Two stages: S1 holds the granted operand, S2 holds the registered result.
module lzd_share_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 48,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*W-1:0]     req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [5:0]            rsp_lzc,
  output logic                  rsp_zero,
  output logic [W-1:0]          rsp_norm
);

  logic [NREQ-1:0][W-1:0] req_op;
  logic [2:1]             vld_pipe;
  logic [IDW-1:0]         ptr, s1_id, gnt_id;
  logic [W-1:0]           s1_op, norm;
  logic [5:0]             lzc;
  logic                   zero, gnt_any, stall;

  assign req_op    = req_data;
  assign rsp_valid = vld_pipe[2];
  assign stall     = vld_pipe[2] & ~rsp_ready;

  // Rotating priority search starting just after the last granted ID.
  always_comb begin
    int j;
    j       = 0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!gnt_any && req_valid[j]) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'(j);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (gnt_any && !stall && !rst) req_ready[gnt_id] = 1'b1;
  end

  // Highest set bit wins because later iterations overwrite earlier ones.
  always_comb begin
    lzc = 6'(W);
    for (int i = 0; i < W; i++)
      if (s1_op[i]) lzc = 6'(W - 1 - i);
    zero = ~|s1_op;
    norm = s1_op << lzc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= IDW'(NREQ - 1);
      vld_pipe <= '0;
      s1_id    <= '0;
      s1_op    <= '0;
      rsp_id   <= '0;
      rsp_lzc  <= '0;
      rsp_zero <= 1'b0;
      rsp_norm <= '0;
    end else if (!stall) begin
      vld_pipe <= {vld_pipe[1], gnt_any};
      if (vld_pipe[1]) begin
        rsp_id   <= s1_id;
        rsp_lzc  <= lzc;
        rsp_zero <= zero;
        rsp_norm <= norm;
      end
      if (gnt_any) begin
        s1_id <= gnt_id;
        s1_op <= req_op[gnt_id];
        ptr   <= gnt_id;
      end
    end
  end

endmodule
